// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers words from a UART receiver in a small FIFO and
// re-issues them, optionally transformed, to a UART transmitter no faster
// than one word per frame time. Also reports the last received word, the
// FIFO level and a saturating count of dropped words.
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int DATA_BIT   = 8,
  parameter int STOP_BIT   = 1,
  parameter int CHECK_BIT  = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic [DATA_BIT-1:0]           rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BIT-1:0]           tx_data,
  output logic                          tx_valid,
  output logic [DATA_BIT-1:0]           led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          full,
  output logic                          empty,
  output logic [7:0]                    ovf_cnt
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int FRAME_CYC = (CLK_FREQ / BAUD_RATE) * (1 + DATA_BIT + CHECK_BIT + STOP_BIT)
                             + GAP_CYCLES;
  localparam int CW        = $clog2(FRAME_CYC + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_BIT-1:0] tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_BIT-1:0] led_q, led_d;
  logic [7:0]          ovf_q, ovf_d;

  logic [DATA_BIT-1:0] mem [FIFO_DEPTH];
  logic [DATA_BIT-1:0] head;
  logic [DATA_BIT-1:0] head_rev;
  logic                full_w, empty_w, pop, push_ok;

  // Head is read combinationally so a word can be popped the edge after it lands.
  assign head    = mem[rd_ptr_q];
  assign full_w  = (level_q == LW'(FIFO_DEPTH));
  assign empty_w = (level_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BIT; gi++) begin : g_rev
      assign head_rev[gi] = head[DATA_BIT-1-gi];
    end
  endgenerate

  // Storage write; a full FIFO still accepts a word when the head leaves on the same edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rx_data;
  end

  // Next-state logic for pointers, level, overflow count and the pacing FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    led_d      = led_q;
    ovf_d      = ovf_q;

    pop     = (state_q == IDLE) && en && !empty_w;
    push_ok = rx_valid && (!full_w || pop);

    if (rx_valid) led_d = rx_data;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (rx_valid && !push_ok && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        // Muted words are drained one per cycle without occupying the line.
        if (pop && (mode != 2'b11)) begin
          case (mode)
            2'b01:   tx_data_d = ~head;
            2'b10:   tx_data_d = head_rev;
            default: tx_data_d = head;
          endcase
          tx_valid_d = 1'b1;
          cnt_d      = CW'(FRAME_CYC - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything immediately, even mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      led_q      <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      led_q      <= led_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign led        = led_q;
  assign fifo_level = level_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: 10 clocks per bit, 8N1 => 100-clock frames, 4-deep FIFO.
module tb_uart_echo_fifo;
  localparam int FRAME = 100;

  logic       clk = 1'b0;
  logic       rst, en, rx_valid;
  logic [1:0] mode;
  logic [7:0] rx_data, tx_data, led, ovf_cnt;
  logic       tx_valid, full, empty;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int level_max = 0;

  typedef struct {int c; logic [7:0] d;} ev_t;
  ev_t evq[$];

  typedef struct {logic [1:0] mode; logic [7:0] rx; logic [7:0] exp;} vec_t;
  vec_t vecs[6];

  uart_echo_fifo #(
    .CLK_FREQ(10), .BAUD_RATE(1), .DATA_BIT(8), .STOP_BIT(1),
    .CHECK_BIT(0), .FIFO_DEPTH(4), .GAP_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid), .led(led),
    .fifo_level(fifo_level), .full(full), .empty(empty), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transmit strobe with its edge number, and the peak level.
  always begin
    @(posedge clk);
    #1;
    if (tx_valid === 1'b1) evq.push_back('{cyc, tx_data});
    if (int'(fifo_level) > level_max) level_max = int'(fifo_level);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  // Check that the recorded events carry exp[] in order, FRAME+1 edges apart.
  task automatic check_stream(input string name, input logic [7:0] exp[$]);
    check({name, " count"}, evq.size(), exp.size());
    for (int j = 0; j < exp.size() && j < evq.size(); j++) begin
      check($sformatf("%s data[%0d]", name, j), evq[j].d, exp[j]);
      if (j > 0) check($sformatf("%s gap[%0d]", name, j), evq[j].c - evq[j-1].c, FRAME + 1);
    end
    $display("%s: %0d words observed", name, evq.size());
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int t0;

    vecs[0] = '{2'b00, 8'hA5, 8'hA5};
    vecs[1] = '{2'b01, 8'hC1, 8'h3E};
    vecs[2] = '{2'b10, 8'hC1, 8'h83};
    vecs[3] = '{2'b00, 8'h3C, 8'h3C};
    vecs[4] = '{2'b01, 8'h00, 8'hFF};
    vecs[5] = '{2'b10, 8'h01, 8'h80};

    rst = 1'b1; en = 1'b1; mode = 2'b00; rx_valid = 1'b0; rx_data = 8'h00;
    tick(2);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst level", fifo_level, 0);
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst ovf", ovf_cnt, 0);
    check("rst led", led, 0);
    rst = 1'b0;
    tick(2);
    $display("reset: state checked");

    // Single echoes and transforms: one word each, latency and data.
    for (int i = 0; i < 6; i++) begin
      evq.delete();
      mode = vecs[i].mode;
      push(vecs[i].rx);
      t0 = cyc;
      check($sformatf("vec%0d led", i), led, vecs[i].rx);
      tick(FRAME + 2);
      check($sformatf("vec%0d count", i), evq.size(), 1);
      if (evq.size() >= 1) begin
        check($sformatf("vec%0d data", i), evq[0].d, vecs[i].exp);
        check($sformatf("vec%0d latency", i), evq[0].c - t0, 1);
        $display("vec%0d: mode %0d rx %02h tx %02h", i, vecs[i].mode, vecs[i].rx, evq[0].d);
      end
    end
    mode = 2'b00;

    // Burst of four back-to-back words: paced output, peak level 3.
    evq.delete();
    level_max = 0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[j]) push(exp_q[j]);
    tick(4 * (FRAME + 1) + 10);
    check_stream("burst", exp_q);
    check("burst peak level", level_max, 3);

    // Overflow with output held.
    en = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'h60 + 8'(i));
    check("ovf full", full, 1);
    check("ovf level", fifo_level, 4);
    check("ovf count", ovf_cnt, 2);
    check("ovf led", led, 8'h66);
    evq.delete();
    en = 1'b1;
    tick(4 * (FRAME + 1) + 10);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    check_stream("overflow", exp_q);
    check("ovf drained", empty, 1);
    check("ovf held", ovf_cnt, 2);

    // Asynchronous reset mid-frame with three words queued.
    evq.delete();
    for (int i = 1; i <= 4; i++) push(8'h70 + 8'(i));
    tick(20);
    check("prerst level", fifo_level, 3);
    #2 rst = 1'b1;
    #1;
    check("inrst tx_valid", tx_valid, 0);
    check("inrst level", fifo_level, 0);
    check("inrst empty", empty, 1);
    check("inrst ovf", ovf_cnt, 0);
    tick(2);
    rst = 1'b0;
    tick();
    check("postrst level", fifo_level, 0);
    check("postrst ovf", ovf_cnt, 0);
    check("postrst led", led, 0);
    evq.delete();
    tick(3 * (FRAME + 1));
    check("postrst no tx", evq.size(), 0);
    check("postrst empty", empty, 1);
    $display("reset mid-frame: queued words discarded");

    // Mute mode drains one word per clock without transmitting.
    mode = 2'b11;
    en = 1'b0;
    for (int i = 1; i <= 3; i++) push(8'h80 + 8'(i));
    check("mute queued", fifo_level, 3);
    evq.delete();
    en = 1'b1;
    tick();
    check("mute lvl1", fifo_level, 2);
    tick();
    check("mute lvl2", fifo_level, 1);
    check("mute not empty", empty, 0);
    tick();
    check("mute empty", empty, 1);
    tick(3);
    check("mute no tx", evq.size(), 0);
    $display("mute: drained 3 words");
    mode = 2'b00;

    // Full FIFO fed one word exactly on each pop: no drops across pointer wrap.
    en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5));
    end
    check("wrap full start", full, 1);
    evq.delete();
    en = 1'b1;
    for (int i = 4; i < 24; i++) begin
      exp_q.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5));
      check($sformatf("wrap full %0d", i), full, 1);
      if (i < 23) tick(FRAME);
    end
    check("wrap ovf", ovf_cnt, 0);
    tick(4 * (FRAME + 1) + 10);
    check_stream("wrap", exp_q);
    check("wrap ovf end", ovf_cnt, 0);
    check("wrap empty end", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
